// File: rtl/execute_muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package execute_muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      FIX
   } state_e;

endpackage

// File: rtl/execute_muldiv_core.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per run cycle.
module muldiv_core #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_i,
   input  logic               run_i,
   input  logic               mul_i,
   input  logic [WIDTH-1:0]   lo_i,
   input  logic [WIDTH-1:0]   op_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic               last_o
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     sum, rem_sh;
   logic [WIDTH-1:0]   diff;

   always_comb begin
      acc_d  = acc_q;
      op_d   = op_q;
      cnt_d  = cnt_q;
      sum    = '0;
      rem_sh = '0;
      diff   = '0;
      if (load_i) begin
         acc_d = {{WIDTH{1'b0}}, lo_i};
         op_d  = op_i;
         cnt_d = CNT_W'(WIDTH - 1);
      end else if (run_i) begin
         if (mul_i) begin
            sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
            acc_d = {sum, acc_q[WIDTH-1:1]};
         end else begin
            // Partial remainder stays below the divisor, so the W-bit difference cannot wrap.
            rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
            diff   = rem_sh[WIDTH-1:0] - op_q;
            if (rem_sh >= {1'b0, op_q})
               acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
            else
               acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
         if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q <= '0;
         op_q  <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         op_q  <= op_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc_o  = acc_q;
   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/execute_muldiv.sv
// Multiply/divide unit beside the execute ALU: FSM, sign handling, HI/LO and stall.
import execute_muldiv_pkg::*;

module execute_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic             mf_req,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e             state_q;
   logic               busy_q, done_q, qsign_q, rsign_q, is_mul_q;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               accept, op_mul, op_signed, s1, s2, div_zero;
   logic [WIDTH-1:0]   mag1, mag2, core_lo, core_op, quo, rem;
   logic [2*WIDTH-1:0] acc, prod;
   logic               last;

   assign accept    = start && (state_q == IDLE) && !md_op[2];
   assign op_mul    = !md_op[1];
   assign op_signed = !md_op[0];
   assign s1        = op_signed & data1[WIDTH-1];
   assign s2        = op_signed & data2[WIDTH-1];
   assign mag1      = s1 ? -data1 : data1;
   assign mag2      = s2 ? -data2 : data2;
   assign div_zero  = md_op[1] && (data2 == '0);

   // A zero divisor runs on the raw dividend with signs cleared, so the
   // datapath itself leaves quotient all-ones and remainder = original data1.
   assign core_lo = op_mul ? mag2 : (div_zero ? data1 : mag1);
   assign core_op = op_mul ? mag1 : mag2;

   muldiv_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clock  (clock),
      .reset  (reset),
      .load_i (accept),
      .run_i  ((state_q == MUL) || (state_q == DIV)),
      .mul_i  (state_q == MUL),
      .lo_i   (core_lo),
      .op_i   (core_op),
      .acc_o  (acc),
      .last_o (last)
   );

   assign prod = qsign_q ? -acc : acc;
   assign quo  = qsign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem  = rsign_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         qsign_q  <= 1'b0;
         rsign_q  <= 1'b0;
         is_mul_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q  <= op_mul ? MUL : DIV;
                  busy_q   <= 1'b1;
                  is_mul_q <= op_mul;
                  qsign_q  <= !div_zero && (s1 ^ s2);
                  rsign_q  <= !div_zero && s1;
               end else if (start && (md_op == MD_MTHI)) begin
                  hi_q <= data1;
               end else if (start && (md_op == MD_MTLO)) begin
                  lo_q <= data1;
               end
            end
            MUL, DIV: begin
               if (last)
                  state_q <= FIX;
            end
            FIX: begin
               if (is_mul_q) begin
                  hi_q <= prod[2*WIDTH-1:WIDTH];
                  lo_q <= prod[WIDTH-1:0];
               end else begin
                  hi_q <= rem;
                  lo_q <= quo;
               end
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign stall = busy_q & (start | mf_req);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: cycle-level arithmetic model compared every cycle, plus directed literals.
module tb_execute_muldiv;

   localparam int W = 32;
   localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
                          OP_MTHI = 3'd4, OP_MTLO = 3'd5;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         mf_req = 1'b0;
   logic [2:0]   md_op = 3'd0;
   logic [W-1:0] data1 = '0, data2 = '0;
   logic         busy, done, stall;
   logic [W-1:0] hi, lo;

   always #5 clock = ~clock;

   execute_muldiv #(.WIDTH(W)) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .md_op  (md_op),
      .data1  (data1),
      .data2  (data2),
      .mf_req (mf_req),
      .busy   (busy),
      .done   (done),
      .stall  (stall),
      .hi     (hi),
      .lo     (lo)
   );

   int passed = 0;
   int total  = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   // Architectural result {hi, lo} from plain integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         OP_MULT:  return sa * sb;
         OP_MULTU: return ua * ub;
         OP_DIV: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         OP_DIVU: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return '0;
      endcase
   endfunction

   logic         m_busy = 1'b0, m_done = 1'b0, armed = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   logic [63:0]  m_pend = '0;
   int           m_left = 0;

   always @(posedge clock) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_left <= 0;
         armed  <= 1'b1;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_hi   <= m_pend[63:32];
               m_lo   <= m_pend[31:0];
            end
            m_left <= m_left - 1;
         end else if (start) begin
            if (!md_op[2]) begin
               m_busy <= 1'b1;
               m_left <= W + 1;
               m_pend <= ref_result(md_op, data1, data2);
            end else if (md_op == OP_MTHI) begin
               m_hi <= data1;
            end else if (md_op == OP_MTLO) begin
               m_lo <= data1;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (armed) begin
         check("cyc busy",  64'(busy),  64'(m_busy));
         check("cyc done",  64'(done),  64'(m_done));
         check("cyc stall", 64'(stall), 64'(m_busy & (start | mf_req)));
         check("cyc hi",    64'(hi),    64'(m_hi));
         check("cyc lo",    64'(lo),    64'(m_lo));
      end
   end

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      md_op = op;
      data1 = a;
      data2 = b;
      @(posedge clock); #1;
      start = 1'b0;
      data1 = $urandom;
      data2 = $urandom;
   endtask

   task automatic wait_done(output int lat, output int bcyc);
      bit seen = 0;
      lat  = 0;
      bcyc = busy ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         lat++;
         if (done) begin
            seen = 1;
            break;
         end
         if (busy) bcyc++;
      end
      check("done seen", 64'(seen), 64'(1));
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      int lat, bcyc;
      issue(op, a, b);
      wait_done(lat, bcyc);
      check({name, " latency"}, 64'(lat), 64'(33));
      check({name, " busy cycles"}, 64'(bcyc), 64'(33));
      check({name, " hi"}, 64'(hi), 64'(exp_hi));
      check({name, " lo"}, 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      int lat, bcyc;
      repeat (2) @(posedge clock); #1;
      reset = 1'b0;
      check("reset hi",   64'(hi),   64'(0));
      check("reset lo",   64'(lo),   64'(0));
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));

      run_op("mult 7*-3",   OP_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("divu 100/7",  OP_DIVU,  32'd100,        32'd7,         32'd2,         32'd14);
      run_op("div -7/2",    OP_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div 7/-2",    OP_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
      run_op("div x/0",     OP_DIV,   32'h1234,       32'd0,         32'h1234,      32'hFFFF_FFFF);
      run_op("div neg/0",   OP_DIV,   32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);
      run_op("div MIN/-1",  OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
      run_op("multu max^2", OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult MIN^2",  OP_MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0);

      // Requests while busy are stalled and ignored; the held mult is taken in the done cycle.
      issue(OP_MULT, 32'd5, 32'd6);
      repeat (4) @(posedge clock); #1;
      start = 1'b1; md_op = OP_MTHI; data1 = 32'hDEAD;
      @(negedge clock);
      check("stall mthi busy", 64'(stall), 64'(1));
      @(posedge clock); #1;
      md_op = OP_MULT; data1 = 32'd3; data2 = 32'd4; mf_req = 1'b1;
      @(negedge clock);
      check("stall mf_req busy", 64'(stall), 64'(1));
      @(posedge clock); #1;
      mf_req = 1'b0;
      wait_done(lat, bcyc);
      check("held hi",          64'(hi),    64'(0));
      check("held lo",          64'(lo),    64'(30));
      check("done cycle stall", 64'(stall), 64'(0));
      check("done cycle busy",  64'(busy),  64'(0));
      @(posedge clock); #1;
      start = 1'b0;
      check("held accept busy", 64'(busy), 64'(1));
      wait_done(lat, bcyc);
      check("held latency", 64'(lat), 64'(33));
      check("held mult hi", 64'(hi),  64'(0));
      check("held mult lo", 64'(lo),  64'(12));

      start = 1'b1; md_op = OP_MTHI; data1 = 32'hCAFE;
      @(posedge clock); #1;
      check("mthi hi",   64'(hi),   64'(32'hCAFE));
      check("mthi busy", 64'(busy), 64'(0));
      md_op = OP_MTLO; data1 = 32'hBEEF;
      @(posedge clock); #1;
      start = 1'b0;
      check("mtlo hi",   64'(hi),   64'(32'hCAFE));
      check("mtlo lo",   64'(lo),   64'(32'hBEEF));
      check("mtlo busy", 64'(busy), 64'(0));
      check("mtlo done", 64'(done), 64'(0));

      start = 1'b1; md_op = 3'd6; data1 = 32'h1111;
      @(posedge clock); #1;
      md_op = 3'd7;
      @(posedge clock); #1;
      start = 1'b0;
      check("reserved busy", 64'(busy), 64'(0));
      check("reserved hi",   64'(hi),   64'(32'hCAFE));
      check("reserved lo",   64'(lo),   64'(32'hBEEF));

      issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("abort busy", 64'(busy), 64'(0));
      check("abort hi",   64'(hi),   64'(0));
      check("abort lo",   64'(lo),   64'(0));
      check("abort done", 64'(done), 64'(0));
      run_op("divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3);

      repeat (2) @(posedge clock); #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
      $fatal(1);
   end

endmodule
